// File: rtl/data_mem_pkg.sv
// Shared types and lane helpers for the byte-lane data memory.
// Latency: n/a (package, combinational helper functions only).
// Backpressure: n/a.
//
// Contents: size encodings, sweep/ready state enum, byte-enable generation
// and load extraction with sign/zero extension. Lane logic assumes a
// 32-bit word made of 4 little-endian byte lanes.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic {
        ST_CLEAR,
        ST_READY
    } state_e;

    // Byte enables for a store of the given size at the given lane.
    // Misaligned combinations still return a mask; the caller gates the
    // write with the error checks.
    function automatic logic [3:0] byte_en(input logic [1:0] size,
                                           input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Pick the addressed byte/half out of a word, shift it down and extend.
    // Word loads ignore the signed flag.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{sgn & b[7]}}, b};
            SZ_HALF: r = {{16{sgn & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables.
// Latency: write lands on the clock edge; read data registered, 1 cycle.
// Backpressure: none; accepts a read and/or write every cycle.
//
// Ports: clk; we (4 byte enables); addr (word index); wdata; rdata
// (registered word at addr, old contents on a same-cycle write).
// Contents are not reset; the owner sweeps them clear after reset.
module data_mem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_bytelane.sv
// Byte/half/word data memory with byte-lane stores, extended loads and a
// post-reset clear sweep. Latency: response 2 edges after... see below.
// Backpressure: req_ready low only during the sweep; responses never stall.
//
// Ports: clk, reset (async, active-low); request side req_valid/req_ready,
// req_wr, req_size, req_signed, addr, wdata; response side resp_valid
// (1-cycle pulse), rdata, err_misalign, err_range.
// Timing: request accepted at edge N reads the array at N; the extended
// result and flags are registered at N+1. Stores write the array at N.
module data_mem_bytelane
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] rdata,
    output logic              err_misalign,
    output logic              err_range
);

    localparam int IDX_W = $clog2(DEPTH);

    state_e             state_q;
    logic [IDX_W-1:0]   clr_idx_q;
    logic               req_ready_q;

    // request decode
    logic [1:0]         lane;
    logic               accept;
    logic               misalign;
    logic               range_err;

    // array port
    logic [3:0]         arr_we;
    logic [IDX_W-1:0]   arr_addr;
    logic [DATA_W-1:0]  arr_wdata;
    logic [DATA_W-1:0]  arr_rdata;

    // stage 1: request attributes travelling alongside the array read
    logic               p_vld_q;
    logic               p_wr_q;
    logic [1:0]         p_size_q;
    logic               p_signed_q;
    logic [1:0]         p_lane_q;
    logic               p_mis_q;
    logic               p_rng_q;

    // stage 2: response registers
    logic               resp_valid_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  rdata_d;
    logic               err_mis_q;
    logic               err_rng_q;

    assign lane      = addr[1:0];
    assign accept    = req_valid && req_ready_q;
    assign misalign  = (req_size == SZ_HALF && addr[0])
                    || (req_size == SZ_WORD && lane != 2'd0)
                    || (req_size == 2'd3);
    // any set bit above the word-index field means index >= DEPTH
    assign range_err = |addr[ADDR_W-1:IDX_W+2];

    // Sweep owns the array port while clearing; otherwise the request does.
    always_comb begin
        arr_we    = 4'b0000;
        arr_addr  = addr[IDX_W+1:2];
        arr_wdata = '0;
        if (state_q == ST_CLEAR) begin
            arr_we   = 4'b1111;
            arr_addr = clr_idx_q;
        end else begin
            if (accept && req_wr && !misalign && !range_err) begin
                arr_we = byte_en(req_size, lane);
            end
            case (req_size)
                SZ_BYTE: arr_wdata = {4{wdata[7:0]}};
                SZ_HALF: arr_wdata = {2{wdata[15:0]}};
                default: arr_wdata = wdata;
            endcase
        end
    end

    data_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (arr_we),
        .addr   (arr_addr),
        .wdata  (arr_wdata),
        .rdata  (arr_rdata)
    );

    // Sweep/ready FSM; req_ready rises on the edge that clears the last word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            req_ready_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    if (clr_idx_q == IDX_W'(DEPTH - 1)) begin
                        state_q     <= ST_READY;
                        req_ready_q <= 1'b1;
                    end else begin
                        clr_idx_q <= clr_idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    req_ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p_vld_q    <= 1'b0;
            p_wr_q     <= 1'b0;
            p_size_q   <= SZ_BYTE;
            p_signed_q <= 1'b0;
            p_lane_q   <= 2'd0;
            p_mis_q    <= 1'b0;
            p_rng_q    <= 1'b0;
        end else begin
            p_vld_q    <= accept;
            p_wr_q     <= req_wr;
            p_size_q   <= req_size;
            p_signed_q <= req_signed;
            p_lane_q   <= lane;
            p_mis_q    <= misalign;
            p_rng_q    <= range_err;
        end
    end

    // Stores and errored accesses return zero data.
    always_comb begin
        rdata_d = '0;
        if (p_vld_q && !p_wr_q && !p_mis_q && !p_rng_q) begin
            rdata_d = load_extract(arr_rdata, p_size_q, p_lane_q, p_signed_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_mis_q    <= 1'b0;
            err_rng_q    <= 1'b0;
        end else begin
            resp_valid_q <= p_vld_q;
            rdata_q      <= rdata_d;
            err_mis_q    <= p_vld_q && p_mis_q;
            err_rng_q    <= p_vld_q && p_rng_q;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign rdata        = rdata_q;
    assign err_misalign = err_mis_q;
    assign err_range    = err_rng_q;

endmodule

// File: tb/tb_data_mem_bytelane.sv
// Directed self-checking bench for data_mem_bytelane (DEPTH 256).
// Inputs are driven on the falling edge, outputs sampled on the falling edge.
// Expected values are hand-computed constants.
module tb_data_mem_bytelane;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_range;

    int n_cmp = 0;
    int n_bad = 0;

    data_mem_bytelane dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wr       (req_wr),
        .req_size     (req_size),
        .req_signed   (req_signed),
        .addr         (addr),
        .wdata        (wdata),
        .resp_valid   (resp_valid),
        .rdata        (rdata),
        .err_misalign (err_misalign),
        .err_range    (err_range)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, exp);
        end
    endtask

    // Single request; returns the response sampled one cycle after acceptance.
    task automatic access(input logic wr, input logic [1:0] size,
                          input logic sgn, input logic [31:0] a,
                          input logic [31:0] wd, input string tag,
                          input logic [31:0] exp_rd, input logic exp_mis,
                          input logic exp_rng);
        @(negedge clk);
        req_valid  = 1'b1;
        req_wr     = wr;
        req_size   = size;
        req_signed = sgn;
        addr       = a;
        wdata      = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        @(negedge clk);
        check_val({tag, ".vld"}, {31'd0, resp_valid}, 32'd1);
        check_val({tag, ".rd"},  rdata, exp_rd);
        check_val({tag, ".mis"}, {31'd0, err_misalign}, {31'd0, exp_mis});
        check_val({tag, ".rng"}, {31'd0, err_range}, {31'd0, exp_rng});
    endtask

    // Counts edges from reset release until req_ready is seen high.
    task automatic sweep_count(input string tag);
        int cnt;
        int pulses;
        cnt    = 0;
        pulses = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
            if (resp_valid) pulses++;
        end while (!req_ready && cnt < 1000);
        req_valid = 1'b0;
        check_val({tag, ".cycles"}, cnt, 32'd256);
        check_val({tag, ".no_resp"}, pulses, 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_wr     = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        addr       = '0;
        wdata      = '0;

        repeat (3) @(negedge clk);
        check_val("rst.ready", {31'd0, req_ready}, 32'd0);
        check_val("rst.vld",   {31'd0, resp_valid}, 32'd0);
        check_val("rst.rdata", rdata, 32'd0);
        check_val("rst.errs",  {30'd0, err_misalign, err_range}, 32'd0);

        // requests during the sweep must be ignored
        reset     = 1'b1;
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'd2;
        addr      = 32'h10;
        wdata     = 32'hCAFEF00D;
        sweep_count("sweep1");

        access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "ld3fc_clr", 32'h0, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h10,  32'h0, "ld10_clr",  32'h0, 1'b0, 1'b0);
        access(1'b1, 2'd2, 1'b0, 32'h3FC, 32'h5A5A5A5A, "st3fc", 32'h0, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "ld3fc", 32'h5A5A5A5A, 1'b0, 1'b0);

        access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, "stw10", 32'h0, 1'b0, 1'b0);
        access(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, "stb12", 32'h0, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, "ldw10", 32'h11AA3344, 1'b0, 1'b0);
        access(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, "ldbs12", 32'hFFFFFFAA, 1'b0, 1'b0);
        access(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, "ldbu12", 32'h000000AA, 1'b0, 1'b0);
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, "ldhs12", 32'h000011AA, 1'b0, 1'b0);
        access(1'b0, 2'd1, 1'b0, 32'h10, 32'h0, "ldhu10", 32'h00003344, 1'b0, 1'b0);
        access(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, "ldbs13", 32'h00000011, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b1, 32'h10, 32'h0, "ldws10", 32'h11AA3344, 1'b0, 1'b0);

        access(1'b1, 2'd2, 1'b0, 32'h11,  32'hFFFFFFFF, "stw11", 32'h0, 1'b1, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h10,  32'h0, "ldw10b", 32'h11AA3344, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, "ldw400", 32'h0, 1'b0, 1'b1);
        access(1'b0, 2'd1, 1'b1, 32'h401, 32'h0, "ldh401", 32'h0, 1'b1, 1'b1);
        access(1'b0, 2'd3, 1'b0, 32'h10,  32'h0, "ldsz3",  32'h0, 1'b1, 1'b0);
        access(1'b1, 2'd1, 1'b0, 32'h13,  32'h0000BEEF, "sth13", 32'h0, 1'b1, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h10,  32'h0, "ldw10c", 32'h11AA3344, 1'b0, 1'b0);

        // back-to-back store then load of the same word
        @(negedge clk);
        req_valid = 1'b1;
        req_wr    = 1'b1;
        req_size  = 2'd2;
        addr      = 32'h20;
        wdata     = 32'hDEADBEEF;
        @(negedge clk);
        req_wr    = 1'b0;
        wdata     = 32'h0;
        @(negedge clk);
        req_valid = 1'b0;
        check_val("b2b.st_vld", {31'd0, resp_valid}, 32'd1);
        check_val("b2b.st_rd",  rdata, 32'd0);
        @(negedge clk);
        check_val("b2b.ld_vld", {31'd0, resp_valid}, 32'd1);
        check_val("b2b.ld_rd",  rdata, 32'hDEADBEEF);
        @(negedge clk);
        check_val("b2b.idle",   {31'd0, resp_valid}, 32'd0);

        // reset lands between acceptance and response: response is dropped
        req_valid = 1'b1;
        req_wr    = 1'b0;
        req_size  = 2'd2;
        addr      = 32'h3FC;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        check_val("drop.vld0", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        check_val("drop.vld1", {31'd0, resp_valid}, 32'd0);
        check_val("drop.ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b1;

        // second reset 100 cycles into the sweep restarts it
        repeat (100) @(negedge clk);
        check_val("mid.ready", {31'd0, req_ready}, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        sweep_count("sweep2");

        access(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, "ld3fc_clr2", 32'h0, 1'b0, 1'b0);
        access(1'b0, 2'd2, 1'b0, 32'h20,  32'h0, "ld20_clr2",  32'h0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
